// File: rtl/pix_stream_pkg.sv
// pix_stream_pkg: address width helper, stored-word field positions and drop-FSM encoding
package pix_stream_pkg;
  typedef enum logic {PASS = 1'b0, DROP = 1'b1} state_t;
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int sop_bit(input int data_w);
    return data_w + 1;
  endfunction
  function automatic int eop_bit(input int data_w);
    return data_w;
  endfunction
endpackage

// File: rtl/pix_stream_fifo_if.sv
// pix_stream_fifo_if: write stream (din*) and show-ahead read stream (dout*, dout_rdy)
// master = producer/consumer side, slave = fifo side
interface pix_stream_fifo_if #(parameter int DATA_W = 1);
  logic [DATA_W-1:0] din, dout;
  logic din_vld, din_sop, din_eop, dout_vld, dout_sop, dout_eop, dout_rdy;
  modport master (output din, din_vld, din_sop, din_eop, dout_rdy, input dout, dout_vld, dout_sop, dout_eop);
  modport slave (input din, din_vld, din_sop, din_eop, dout_rdy, output dout, dout_vld, dout_sop, dout_eop);
endinterface

// File: rtl/pix_stream_ram.sv
// pix_stream_ram: simple dual-port ram, one write port, one registered read port held when re=0
// ports: clk, we/wa/wd write, re/ra read request, q registered read data
module pix_stream_ram
  import pix_stream_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 1024
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [addr_w(DEPTH)-1:0]   wa,
  input  logic [WIDTH-1:0]           wd,
  input  logic                       re,
  input  logic [addr_w(DEPTH)-1:0]   ra,
  output logic [WIDTH-1:0]           q
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) q <= mem[ra];
  end
endmodule

// File: rtl/pix_stream_fifo.sv
// pix_stream_fifo: frame-aware show-ahead stream fifo that drops the rest of a frame on overflow
// ports: clk, rst_n (async, active-low), s (stream interface, slave side),
//        full/empty/almost_full/usedw status, drop_cnt saturating dropped-frame count
module pix_stream_fifo
  import pix_stream_pkg::*;
#(
  parameter int DATA_W    = 1,
  parameter int DEPTH     = 1024,
  parameter int AF_LEVEL  = DEPTH - 16,
  parameter bit DROP_MODE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pix_stream_fifo_if.slave       s,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic [addr_w(DEPTH):0] usedw,
  output logic [15:0]            drop_cnt
);
  localparam int AW = addr_w(DEPTH);
  localparam int WW = DATA_W + 2;
  localparam logic [AW:0] ONE = 1;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_LVL = (AW+1)'(AF_LEVEL);
  state_t state;
  logic [AW:0] wr_ptr, rd_ptr, usedw_n;
  logic [WW-1:0] q;
  logic q_vld, we, re, pop, load, ovf, drop_inc;
  // q acts as a second pipeline slot: the ram holds its read register while the output is stalled
  assign pop = s.dout_vld && s.dout_rdy;
  assign load = q_vld && (!s.dout_vld || pop);
  assign re = (wr_ptr != rd_ptr) && (!q_vld || load);
  assign we = s.din_vld && !full && (state == PASS || s.din_sop);
  assign ovf = s.din_vld && full;
  assign drop_inc = ovf && (state == DROP ? s.din_sop : DROP_MODE);
  assign usedw_n = usedw + (we ? ONE : '0) - (pop ? ONE : '0);
  pix_stream_ram #(.WIDTH(WW), .DEPTH(DEPTH)) ram (
    .clk, .we, .wa(wr_ptr[AW-1:0]), .wd({s.din_sop, s.din_eop, s.din}),
    .re, .ra(rd_ptr[AW-1:0]), .q
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= PASS;
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_vld <= 1'b0;
      s.dout <= '0;
      s.dout_vld <= 1'b0;
      s.dout_sop <= 1'b0;
      s.dout_eop <= 1'b0;
      usedw <= '0;
      full <= 1'b0;
      empty <= 1'b1;
      almost_full <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (we) wr_ptr <= wr_ptr + ONE;
      if (re) rd_ptr <= rd_ptr + ONE;
      q_vld <= re || (q_vld && !load);
      if (load) begin
        s.dout <= q[DATA_W-1:0];
        s.dout_sop <= q[sop_bit(DATA_W)];
        s.dout_eop <= q[eop_bit(DATA_W)];
      end
      s.dout_vld <= load || (s.dout_vld && !pop);
      usedw <= usedw_n;
      full <= usedw_n == FULL_LVL;
      empty <= usedw_n == '0;
      almost_full <= usedw_n >= AF_LVL;
      if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (ovf && state == PASS && !s.din_eop && DROP_MODE) state <= DROP;
      else if (state == DROP && we) state <= PASS;
    end
endmodule

// File: tb/tb_pix_stream_fifo.sv
// tb_pix_stream_fifo: directed stimulus with a queue-based reference model and literal pins
module tb_pix_stream_fifo;
  localparam int DW = 8, DP = 16, AF = 12;
  logic clk = 1'b0, rst_n = 1'b0;
  logic full, empty, almost_full;
  logic [4:0] usedw;
  logic [15:0] drop_cnt;
  int checks = 0, failures = 0;
  pix_stream_fifo_if #(.DATA_W(DW)) bus ();
  pix_stream_fifo #(.DATA_W(DW), .DEPTH(DP), .AF_LEVEL(AF), .DROP_MODE(1'b1)) dut (
    .clk, .rst_n, .s(bus), .full, .empty, .almost_full, .usedw, .drop_cnt
  );
  always #5 clk = ~clk;
  logic [9:0] m_q[$];
  logic [9:0] got[$];
  bit m_drop;
  int m_cnt;
  logic p_vld, p_rdy;
  logic [9:0] p_word;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask
  function automatic logic [9:0] gw(input int i);
    return (i < got.size()) ? got[i] : 10'h3ff;
  endfunction
  // reference model: words held = queue contents; checks current outputs, then applies the coming edge
  always @(negedge clk) begin
    logic [9:0] w;
    bit fm, wm;
    w = {bus.dout_sop, bus.dout_eop, bus.dout};
    if (!rst_n) begin
      chk("rst_out", {bus.dout_vld, w}, 32'd0);
      chk("rst_flags", {full, empty, almost_full, usedw}, {1'b0, 1'b1, 1'b0, 5'd0});
      chk("rst_cnt", drop_cnt, 32'd0);
      m_q.delete();
      m_drop = 0;
      m_cnt = 0;
      p_vld = 0;
    end else begin
      chk("usedw", usedw, m_q.size());
      chk("full", full, m_q.size() == DP);
      chk("empty", empty, m_q.size() == 0);
      chk("almost_full", almost_full, m_q.size() >= AF);
      chk("drop_cnt", drop_cnt, m_cnt);
      if (bus.dout_vld) begin
        chk("vld_nonempty", m_q.size() != 0, 1);
        if (m_q.size() != 0) chk("head", w, m_q[0]);
      end
      if (p_vld && !p_rdy) chk("hold", {bus.dout_vld, w}, {1'b1, p_word});
      p_vld = bus.dout_vld;
      p_rdy = bus.dout_rdy;
      p_word = w;
      fm = m_q.size() == DP;
      wm = bus.din_vld && !fm && (!m_drop || bus.din_sop);
      if (bus.dout_vld && bus.dout_rdy && m_q.size() != 0) begin
        got.push_back(w);
        void'(m_q.pop_front());
      end
      if (bus.din_vld && fm) begin
        if (!m_drop) begin
          if (m_cnt < 65535) m_cnt++;
          if (!bus.din_eop) m_drop = 1;
        end else if (bus.din_sop && m_cnt < 65535) m_cnt++;
      end
      if (wm) begin
        m_q.push_back({bus.din_sop, bus.din_eop, bus.din});
        m_drop = 0;
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [7:0] d, input logic sop, input logic eop);
    bus.din_vld = 1'b1;
    bus.din = d;
    bus.din_sop = sop;
    bus.din_eop = eop;
    step();
  endtask
  task automatic idle(input int n);
    bus.din_vld = 1'b0;
    bus.din_sop = 1'b0;
    bus.din_eop = 1'b0;
    repeat (n) step();
  endtask
  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    bus.din = '0;
    bus.din_vld = 1'b0;
    bus.din_sop = 1'b0;
    bus.din_eop = 1'b0;
    bus.dout_rdy = 1'b0;
    repeat (2) step();
    chk("reset_state", {bus.dout_vld, empty, usedw}, {1'b0, 1'b1, 5'd0});
    rst_n = 1'b1;
    step();
    bus.dout_rdy = 1'b1;
    got.delete();
    for (int i = 0; i < 10; i++) begin
      beat(8'(i), i == 0, i == 9);
      if (i == 1) chk("lat_n1_vld", bus.dout_vld, 0);
      if (i == 2) chk("lat_n2_head", {bus.dout_vld, bus.dout_sop, bus.dout}, {1'b1, 1'b1, 8'h00});
    end
    idle(4);
    chk("t1_empty", empty, 1);
    chk("t1_count", got.size(), 10);
    for (int i = 0; i < 10; i++) chk("t1_data", gw(i), {i == 0, i == 9, 8'(i)});
    bus.dout_rdy = 1'b0;
    got.delete();
    for (int i = 0; i < 16; i++) begin
      beat(8'(i), i == 0, 1'b0);
      if (i == 10) chk("t2_af_11", {usedw, almost_full}, {5'd11, 1'b0});
      if (i == 11) chk("t2_af_12", {usedw, almost_full}, {5'd12, 1'b1});
    end
    chk("t2_full", {full, usedw}, {1'b1, 5'd16});
    chk("t2_head", {bus.dout_vld, bus.dout}, {1'b1, 8'h00});
    beat(8'h10, 1'b0, 1'b0);
    chk("t3_drop1", {drop_cnt, usedw}, {16'd1, 5'd16});
    beat(8'h11, 1'b0, 1'b0);
    chk("t3_still1", drop_cnt, 1);
    beat(8'hE0, 1'b1, 1'b0);
    chk("t4_drop2", {drop_cnt, usedw}, {16'd2, 5'd16});
    bus.dout_rdy = 1'b1;
    beat(8'h12, 1'b0, 1'b0);
    beat(8'h13, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) beat(8'hA0 + 8'(i), i == 0, i == 3);
    idle(24);
    chk("t3_count", got.size(), 20);
    for (int i = 0; i < 16; i++) chk("t3_old", gw(i), {i == 0, 1'b0, 8'(i)});
    for (int i = 0; i < 4; i++) chk("t3_new", gw(16 + i), {i == 0, i == 3, 8'hA0 + 8'(i)});
    chk("t3_end", {empty, drop_cnt}, {1'b1, 16'd2});
    bus.dout_rdy = 1'b0;
    got.delete();
    for (int i = 0; i < 8; i++) beat(8'h40 + 8'(i), i == 0, 1'b0);
    idle(2);
    chk("t5_start", {bus.dout_vld, usedw}, {1'b1, 5'd8});
    bus.dout_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      beat(8'h48 + 8'(i), 1'b0, i == 19);
      chk("t5_usedw", usedw, 8);
    end
    idle(12);
    chk("t5_count", got.size(), 28);
    for (int i = 0; i < 28; i++) chk("t5_data", gw(i), {i == 0, i == 27, 8'h40 + 8'(i)});
    bus.dout_rdy = 1'b0;
    got.delete();
    for (int i = 0; i < 16; i++) beat(8'h80 + 8'(i), i == 0, 1'b0);
    beat(8'h90, 1'b0, 1'b0);
    chk("t6_drop3", drop_cnt, 3);
    bus.din_vld = 1'b0;
    bus.dout_rdy = 1'b1;
    n = 0;
    while (usedw != 5 && n < 40) begin
      step();
      n++;
    end
    bus.dout_rdy = 1'b0;
    chk("t6_reach5", usedw, 5);
    step();
    chk("t6_hold5", {bus.dout_vld, usedw}, {1'b1, 5'd5});
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_out", {bus.dout_vld, bus.dout_sop, bus.dout_eop, bus.dout}, 32'd0);
    chk("t6_async_flags", {full, empty, almost_full, usedw}, {1'b0, 1'b1, 1'b0, 5'd0});
    chk("t6_async_cnt", drop_cnt, 0);
    repeat (2) step();
    rst_n = 1'b1;
    beat(8'h77, 1'b0, 1'b0);
    chk("t6_pass_write", usedw, 1);
    bus.dout_rdy = 1'b1;
    idle(4);
    chk("t6_pass_out", gw(got.size() - 1), {2'b00, 8'h77});
    chk("t6_empty", empty, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
